led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the board's free-running LED counter: a fully synchronous prescaler plus an N-bit LED pattern engine with selectable modes, direction, run/step control and wrap indication.
- Replaces the overflow-clocked 3-bit counter. Every register is on the single system clock; the prescaler only produces an enable.
- Sits between the top level and the board LEDs. tick_o and leds_o can also feed display drivers.

Parameters:
- N_LEDS, 8, pattern width. Minimum 2.
- DIV_W, 32, prescaler width.
- DEFAULT_DIV, 5_000_000, reload value after reset: clk cycles per pattern step.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- div_i  in  DIV_W  new prescaler value.
- div_load_i  in  1  one-cycle strobe that latches div_i.
- mode_i  in  3  pattern mode: 0 binary, 1 gray, 2 rotate, 3 bounce, 4 blink, 5 fill, 6-7 hold.
- dir_i  in  1  1 = up/left, 0 = down/right. Used by modes 0-2.
- run_i  in  1  1 = advance on prescaler tick.
- step_i  in  1  one-cycle single-step request. Honoured only while run_i = 0.
- leds_o  out  N_LEDS  registered pattern.
- tick_o  out  1  registered one-cycle pulse, high in the cycle leds_o shows a newly advanced value.
- wrap_o  out  1  registered one-cycle pulse, high when the advanced value equals the mode seed.

Behaviour:
- Reset (rst = 0, async):
  - div_reg = DEFAULT_DIV, prescaler = 0, count = 0, mode_reg = 0, bounce_dir = left.
  - leds_o = 0, tick_o = 0, wrap_o = 0.
- Prescaler:
  - Increments each clk while run_i = 1.
  - When it reaches div_reg - 1: it returns to 0 and asserts internal tick for one cycle.
  - div_reg of 0 or 1 gives a tick every cycle.
  - run_i = 0 freezes the prescaler without clearing it.
  - div_load_i: div_reg <= div_i and prescaler <= 0 on the same edge. Any tick in that cycle is suppressed.
- Advance enable:
  - adv = (tick & run_i) | (step_i & ~run_i).
  - A simultaneous tick and step gives exactly one advance.
  - Latency: pattern registers update on the edge ending the adv cycle. tick_o and wrap_o are high during the following cycle, aligned with the new leds_o.
- Mode change:
  - mode_reg samples mode_i every cycle. When mode_i differs from mode_reg, that edge loads the new mode's seed, clears the prescaler and bounce_dir = left. No advance occurs in that cycle and tick_o/wrap_o stay 0.
- Modes (per adv):
  - 0 binary: count +1 (dir_i = 1) or -1, modulo 2^N_LEDS. leds_o = count. Seed 0.
  - 1 gray: count as in mode 0. leds_o = count ^ (count >> 1). Seed 0.
  - 2 rotate: one-hot, seed 1. Rotate left (dir_i = 1) or right, wrapping MSB<->LSB.
  - 3 bounce: one-hot, seed 1, dir_i ignored.
    - Shift per bounce_dir.
    - On reaching the MSB, bounce_dir flips to right; on reaching the LSB, it flips to left.
    - Period 2*(N_LEDS-1) steps.
  - 4 blink: seed 0. Each adv inverts all bits (0 <-> all ones).
  - 5 fill: seed 0. Each adv does leds = {leds[N-2:0], 1'b1}. The step after all ones returns to 0. Period N_LEDS+1 steps.
  - 6-7 hold: leds_o frozen. tick_o still pulses on adv; wrap_o = 0.
- wrap_o: set when the post-advance leds_o equals the mode seed. In modes 0-1, set when count wraps in either direction.
- Reset mid-operation: all state returns to reset values immediately. The first tick after release arrives DEFAULT_DIV cycles after run_i = 1.
- Signal sourcing:
  - dir_i is sampled at the adv edge only. Changing it between steps takes effect on the next step.
  - All outputs are driven directly from flops. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, N_LEDS=4, div loaded to 3, mode 0, dir 1, run 1 -> leds_o 0,1,2,3,... changing every 3 clks. After 0xF the next step gives 0, with wrap_o and tick_o both high for 1 cycle.
- Mode 1, dir 0, from count 0 -> leds_o 1000 (count 0xF), then 1001 (0xE), then 1011 (0xD), then 1010 (0xC); wrap_o high on the first step.
- Mode 3, N_LEDS=4 -> leds_o 0001,0010,0100,1000,0100,0010,0001. wrap_o high only on the 0001 return (step 6).
- run 0, step_i pulsed 5 times in mode 5 -> leds_o 0001,0011,0111,1111,0000. wrap_o high on 0000. The prescaler is frozen (no tick_o between steps).
- Change mode_i 0->2 mid-count with a tick in the same cycle -> next cycle leds_o = 0001, tick_o = 0. The next tick is 3 clks later and gives 0010.
- Assert rst low for 1 clk mid-pattern with div 0 -> outputs 0 immediately. After release, the prescaler uses DEFAULT_DIV (the test override is 5) and the first tick_o appears 5 clks after release.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern engine: synchronous prescaler enable driving an N-bit pattern
// generator with selectable modes, direction, run/step control and wrap pulse.
module led_pattern_gen #(
  parameter int          N_LEDS      = 8,
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              div_load_i,
  input  logic [2:0]        mode_i,
  input  logic              dir_i,
  input  logic              run_i,
  input  logic              step_i,
  output logic [N_LEDS-1:0] leds_o,
  output logic              tick_o,
  output logic              wrap_o
);

  typedef enum logic [2:0] {
    M_BINARY = 3'd0,
    M_GRAY   = 3'd1,
    M_ROTATE = 3'd2,
    M_BOUNCE = 3'd3,
    M_BLINK  = 3'd4,
    M_FILL   = 3'd5,
    M_HOLD6  = 3'd6,
    M_HOLD7  = 3'd7
  } mode_t;

  localparam logic [N_LEDS-1:0] ONES = '1;
  localparam logic [N_LEDS-1:0] ONE  = N_LEDS'(1);

  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  presc;
  logic [N_LEDS-1:0] count;
  mode_t             mode_reg;
  logic              bounce_left;

  logic              tick, adv, mode_chg;
  logic [N_LEDS-1:0] count_nxt, leds_nxt;
  logic              wrap_nxt, bounce_left_nxt;

  function automatic logic [N_LEDS-1:0] to_gray(input logic [N_LEDS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Hold modes have no seed of their own: entering them keeps the display.
  function automatic logic [N_LEDS-1:0] seed_of(input logic [2:0] m,
                                                input logic [N_LEDS-1:0] cur);
    case (m)
      3'd2, 3'd3: return ONE;
      3'd6, 3'd7: return cur;
      default:    return '0;
    endcase
  endfunction

  assign mode_chg = (mode_i != 3'(mode_reg));
  assign tick     = run_i & ((div_reg <= DIV_W'(1)) | (presc >= div_reg - DIV_W'(1)));
  assign adv      = ~mode_chg & ((tick & ~div_load_i) | (step_i & ~run_i));

  always_comb begin
    count_nxt       = count;
    leds_nxt        = leds_o;
    wrap_nxt        = 1'b0;
    bounce_left_nxt = bounce_left;
    case (mode_reg)
      M_BINARY, M_GRAY: begin
        count_nxt = dir_i ? count + N_LEDS'(1) : count - N_LEDS'(1);
        wrap_nxt  = dir_i ? (count == ONES) : (count == '0);
        leds_nxt  = (mode_reg == M_GRAY) ? to_gray(count_nxt) : count_nxt;
      end
      M_ROTATE: begin
        leds_nxt = dir_i ? {leds_o[N_LEDS-2:0], leds_o[N_LEDS-1]}
                         : {leds_o[0], leds_o[N_LEDS-1:1]};
        wrap_nxt = (leds_nxt == ONE);
      end
      M_BOUNCE: begin
        if (bounce_left) begin
          leds_nxt = leds_o << 1;
          if (leds_nxt[N_LEDS-1]) bounce_left_nxt = 1'b0;
        end else begin
          leds_nxt = leds_o >> 1;
          if (leds_nxt[0]) bounce_left_nxt = 1'b1;
        end
        wrap_nxt = (leds_nxt == ONE);
      end
      M_BLINK: begin
        leds_nxt = ~leds_o;
        wrap_nxt = (leds_nxt == '0);
      end
      M_FILL: begin
        leds_nxt = (leds_o == ONES) ? '0 : {leds_o[N_LEDS-2:0], 1'b1};
        wrap_nxt = (leds_nxt == '0);
      end
      default: begin
        leds_nxt = leds_o;
        wrap_nxt = 1'b0;
      end
    endcase
  end

  // Single register stage: prescaler, pattern state and output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg     <= DIV_W'(DEFAULT_DIV);
      presc       <= '0;
      count       <= '0;
      mode_reg    <= M_BINARY;
      bounce_left <= 1'b1;
      leds_o      <= '0;
      tick_o      <= 1'b0;
      wrap_o      <= 1'b0;
    end else begin
      mode_reg <= mode_t'(mode_i);
      tick_o   <= adv;
      wrap_o   <= adv & wrap_nxt;
      if (div_load_i) div_reg <= div_i;
      if (div_load_i || mode_chg) presc <= '0;
      else if (run_i)             presc <= tick ? '0 : presc + DIV_W'(1);
      if (mode_chg) begin
        leds_o      <= seed_of(mode_i, leds_o);
        count       <= '0;
        bounce_left <= 1'b1;
      end else if (adv) begin
        leds_o      <= leds_nxt;
        count       <= count_nxt;
        bounce_left <= bounce_left_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized traffic,
// checked every cycle against a phase-counting reference model.
module tb_led_pattern_gen;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam int DD = 5;

  logic          clk;
  logic          rst;
  logic [DW-1:0] div_i;
  logic          div_load_i;
  logic [2:0]    mode_i;
  logic          dir_i;
  logic          run_i;
  logic          step_i;
  logic [NL-1:0] leds_o;
  logic          tick_o;
  logic          wrap_o;

  led_pattern_gen #(.N_LEDS(NL), .DIV_W(DW), .DEFAULT_DIV(DD)) dut (
    .clk(clk), .rst(rst), .div_i(div_i), .div_load_i(div_load_i),
    .mode_i(mode_i), .dir_i(dir_i), .run_i(run_i), .step_i(step_i),
    .leds_o(leds_o), .tick_o(tick_o), .wrap_o(wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: patterns are derived from a counter value or a phase index.
  int m_div, m_pre, m_mode, m_cnt, m_ph;
  logic [NL-1:0] m_leds;
  logic m_tick, m_wrap;

  function automatic logic [NL-1:0] patt(input int md, input int c, input int p);
    case (md)
      0: return NL'(c);
      1: return NL'(c ^ (c >> 1));
      2: return NL'(1 << p);
      3: return (p < NL) ? NL'(1 << p) : NL'(1 << (2 * (NL - 1) - p));
      4: return (p != 0) ? NL'((1 << NL) - 1) : '0;
      5: return NL'((1 << p) - 1);
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_div = DD; m_pre = 0; m_mode = 0; m_cnt = 0; m_ph = 0;
    m_leds = '0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step();
    bit chg, tk, adv;
    int old;
    chg = (int'(mode_i) != m_mode);
    tk  = run_i && (m_pre + 1 >= m_div);
    adv = !chg && ((tk && !div_load_i) || (step_i && !run_i));
    if (div_load_i || chg) m_pre = 0;
    else if (run_i)        m_pre = tk ? 0 : m_pre + 1;
    if (div_load_i) m_div = int'(div_i);
    m_tick = adv;
    m_wrap = 1'b0;
    if (chg) begin
      m_mode = int'(mode_i);
      m_cnt = 0;
      m_ph = 0;
      if (m_mode < 6) m_leds = patt(m_mode, m_cnt, m_ph);
    end else if (adv) begin
      case (m_mode)
        0, 1: begin
          old = m_cnt;
          m_cnt = (m_cnt + (dir_i ? 1 : (1 << NL) - 1)) % (1 << NL);
          m_wrap = dir_i ? (old == (1 << NL) - 1) : (old == 0);
        end
        2: begin m_ph = (m_ph + (dir_i ? 1 : NL - 1)) % NL;  m_wrap = (m_ph == 0); end
        3: begin m_ph = (m_ph + 1) % (2 * (NL - 1));         m_wrap = (m_ph == 0); end
        4: begin m_ph = (m_ph + 1) % 2;                      m_wrap = (m_ph == 0); end
        5: begin m_ph = (m_ph + 1) % (NL + 1);               m_wrap = (m_ph == 0); end
        default: ;
      endcase
      if (m_mode < 6) m_leds = patt(m_mode, m_cnt, m_ph);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("leds", 32'(leds_o), 32'(m_leds));
    chk("tick", 32'(tick_o), 32'(m_tick));
    chk("wrap", 32'(wrap_o), 32'(m_wrap));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    chk("rst_leds", 32'(leds_o), 32'(0));
    chk("rst_tick", 32'(tick_o), 32'(0));
    chk("rst_wrap", 32'(wrap_o), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [NL-1:0] fill_exp [5];

  initial begin
    fill_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    rst = 1'b1; div_i = '0; div_load_i = 1'b0; mode_i = 3'd0;
    dir_i = 1'b1; run_i = 1'b0; step_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Binary up with divider 3, through a full wrap.
    div_i = 8'd3; div_load_i = 1'b1; run_i = 1'b1;
    cycle();
    div_load_i = 1'b0;
    repeat (52) cycle();

    // Gray down.
    mode_i = 3'd1; dir_i = 1'b0;
    repeat (15) cycle();

    // Bounce.
    mode_i = 3'd3; dir_i = 1'b1;
    repeat (25) cycle();

    // Single-step fill with the prescaler frozen.
    run_i = 1'b0; mode_i = 3'd5;
    cycle();
    for (int k = 0; k < 5; k++) begin
      step_i = 1'b1;
      cycle();
      chk("fill_leds", 32'(leds_o), 32'(fill_exp[k]));
      chk("fill_tick", 32'(tick_o), 32'(1));
      chk("fill_wrap", 32'(wrap_o), 32'(k == 4));
      step_i = 1'b0;
      cycle();
      cycle();
      chk("fill_idle", 32'(tick_o), 32'(0));
    end

    // Mode change coinciding with a prescaler tick.
    mode_i = 3'd0; dir_i = 1'b1; run_i = 1'b1;
    repeat (4) cycle();
    begin
      int guard = 0;
      while (!(m_pre + 1 >= m_div) && guard < 20) begin
        cycle();
        guard++;
      end
      chk("align_bound", 32'(guard < 20), 32'(1));
    end
    mode_i = 3'd2;
    cycle();
    chk("chg_leds", 32'(leds_o), 32'(1));
    chk("chg_tick", 32'(tick_o), 32'(0));
    repeat (3) cycle();
    chk("chg_next_leds", 32'(leds_o), 32'(2));
    chk("chg_next_tick", 32'(tick_o), 32'(1));

    // Divider 0, then reset mid-pattern; first tick after DEFAULT_DIV cycles.
    mode_i = 3'd0; div_i = 8'd0; div_load_i = 1'b1;
    cycle();
    div_load_i = 1'b0;
    repeat (6) cycle();
    do_reset();
    for (int c = 1; c <= DD + 1; c++) begin
      cycle();
      chk("post_rst_tick", 32'(tick_o), 32'(c == DD));
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode_i = 3'($urandom_range(0, 7));
      dir_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) run_i = ~run_i;
      step_i = ($urandom_range(0, 3) == 0);
      div_load_i = ($urandom_range(0, 99) == 0);
      div_i = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
